wb_regfile: RTL

//  Consumer end of the MEM/WB pipeline register: the writeback stage plus the architectural register file.

---
 rtl/wb_regfile_pkg.sv | 48 ++++
 rtl/wb_regfile_load_align.sv | 49 ++++
 rtl/wb_regfile.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// ----------------------------------------------------------------------------
// riscv_wb_pkg
// Shared definitions for the writeback stage and register file of the
// pipelined BRAM core.
//   XLEN         datapath width (only 32 is supported)
//   NREGS        number of architectural registers (x0 hardwired to zero)
//   CNT_W        width of the retired-instruction counter
//   result_src_t writeback result selector encoding
//   F3_*         load funct3 encodings used by the load aligner
//   extendLoad   sign/zero extension of an aligned byte or halfword
// ----------------------------------------------------------------------------
package riscv_wb_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int CNT_W = 64;

    // Writeback result source, matching the ResultSrcW encoding of the MEM/WB bank
    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } result_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Extends either the low byte or the full halfword of an already shifted
    // value to XLEN bits, replicating the top bit of the field when signed.
    function automatic logic [XLEN-1:0] extendLoad(
        input logic [15:0] half,
        input logic        isByte,
        input logic        isSigned
    );
        logic [XLEN-1:0] result;
        if (isByte) begin
            result = {{(XLEN-8){isSigned & half[7]}}, half[7:0]};
        end else begin
            result = {{(XLEN-16){isSigned & half[15]}}, half};
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_regfile_load_align.sv
// ----------------------------------------------------------------------------
// load_align
// Combinational load data aligner. Shifts the raw BRAM word right by the
// byte offset of the access and sign/zero extends the addressed byte or
// halfword. Word loads and the unused funct3 codes pass the raw word through.
// Ports:
//   rawWord_i  raw 32-bit word read from BRAM
//   byteOff_i  address[1:0] of the load
//   funct3_i   load size/sign selector
//   aligned_o  aligned and extended load result
// ----------------------------------------------------------------------------
module load_align
    import riscv_wb_pkg::*;
(
    input  logic [XLEN-1:0] rawWord_i,
    input  logic [1:0]      byteOff_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] aligned_o
);

    logic [15:0] shiftedHalf;

    // Low halfword of the word shifted right by 8*offset. Offset 3 only has
    // one byte left, so the upper byte comes in as zero from the shift.
    always_comb begin
        shiftedHalf = rawWord_i[15:0];
        case (byteOff_i)
            2'd0:    shiftedHalf = rawWord_i[15:0];
            2'd1:    shiftedHalf = rawWord_i[23:8];
            2'd2:    shiftedHalf = rawWord_i[31:16];
            default: shiftedHalf = {8'h00, rawWord_i[31:24]};
        endcase
    end

    // Size/sign selection; anything that is not a byte or halfword load is
    // treated as a full-word load and ignores the offset.
    always_comb begin
        aligned_o = rawWord_i;
        case (funct3_i)
            F3_LB:   aligned_o = extendLoad(shiftedHalf, 1'b1, 1'b1);
            F3_LH:   aligned_o = extendLoad(shiftedHalf, 1'b0, 1'b1);
            F3_LBU:  aligned_o = extendLoad(shiftedHalf, 1'b1, 1'b0);
            F3_LHU:  aligned_o = extendLoad(shiftedHalf, 1'b0, 1'b0);
            F3_LW:   aligned_o = rawWord_i;
            default: aligned_o = rawWord_i;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// ----------------------------------------------------------------------------
// wb_regfile
// Writeback stage plus architectural register file of the pipelined BRAM
// core. Selects the final result of the instruction in the MEM/WB slot,
// commits it to the 32x32 register file, serves the two ID-stage read ports
// and counts retired instructions.
// Configuration macro:
//   WB_BYPASS_EN  when defined, a read of the register being committed in the
//                 same cycle returns the new value (write-then-read bypass).
// Ports:
//   clk         core clock, rising edge
//   reset       synchronous, active-high
//   ValidW      MEM/WB slot holds a real instruction
//   RegWriteW   instruction writes rd
//   ResultSrcW  result select: ALU / load / PC+4 / immediate
//   Funct3W     load size/sign selector
//   ByteOffW    address[1:0] of the load
//   ALUResultW  ALU result
//   ReadDataW   raw BRAM word
//   PCPlus4W    link value for JAL/JALR
//   ImmExtW     extended immediate
//   RdW         destination register
//   A1, A2      ID-stage read addresses
//   RD1, RD2    read data
//   ResultW     selected writeback value (also the hazard forward path)
//   InstRet     retired-instruction count
// ----------------------------------------------------------------------------
module wb_regfile #(
    parameter int XLEN  = riscv_wb_pkg::XLEN,
    parameter int NREGS = riscv_wb_pkg::NREGS,
    parameter int CNT_W = riscv_wb_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidW,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcW,
    input  logic [2:0]       Funct3W,
    input  logic [1:0]       ByteOffW,
    input  logic [XLEN-1:0]  ALUResultW,
    input  logic [XLEN-1:0]  ReadDataW,
    input  logic [XLEN-1:0]  PCPlus4W,
    input  logic [XLEN-1:0]  ImmExtW,
    input  logic [4:0]       RdW,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    output logic [XLEN-1:0]  RD1,
    output logic [XLEN-1:0]  RD2,
    output logic [XLEN-1:0]  ResultW,
    output logic [CNT_W-1:0] InstRet
);

    import riscv_wb_pkg::*;

    logic [XLEN-1:0]  rf_q [NREGS];
    logic [XLEN-1:0]  loadData;
    logic             commitWe;
    logic [CNT_W-1:0] instRet_q;
    logic [CNT_W-1:0] instRet_d;

    load_align uLoadAlign (
        .rawWord_i (ReadDataW),
        .byteOff_i (ByteOffW),
        .funct3_i  (Funct3W),
        .aligned_o (loadData)
    );

    // Final result mux. Purely combinational so the hazard unit sees the
    // value in the same cycle; it is computed even for bubbles.
    always_comb begin
        ResultW = ALUResultW;
        case (result_src_t'(ResultSrcW))
            RES_ALU:  ResultW = ALUResultW;
            RES_LOAD: ResultW = loadData;
            RES_PC4:  ResultW = PCPlus4W;
            RES_IMM:  ResultW = ImmExtW;
            default:  ResultW = ALUResultW;
        endcase
    end

    // Only real instructions that write a non-zero rd touch storage.
    assign commitWe = ValidW & RegWriteW & (RdW != 5'd0);

    // Register storage. Reset clears every entry and takes priority over a
    // commit in the same cycle, so an in-flight write is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (commitWe) begin
            rf_q[RdW] <= ResultW;
        end
    end

    // Asynchronous read ports. x0 is forced to zero on the read side, which
    // also covers the bypass path when rd is x0.
`ifdef WB_BYPASS_EN
    always_comb begin
        RD1 = rf_q[A1];
        if (A1 == 5'd0) begin
            RD1 = '0;
        end else if (commitWe && (A1 == RdW)) begin
            RD1 = ResultW;
        end
    end

    always_comb begin
        RD2 = rf_q[A2];
        if (A2 == 5'd0) begin
            RD2 = '0;
        end else if (commitWe && (A2 == RdW)) begin
            RD2 = ResultW;
        end
    end
`else
    always_comb begin
        RD1 = rf_q[A1];
        if (A1 == 5'd0) begin
            RD1 = '0;
        end
    end

    always_comb begin
        RD2 = rf_q[A2];
        if (A2 == 5'd0) begin
            RD2 = '0;
        end
    end
`endif

    // Retired-instruction count: every valid slot counts, whether or not it
    // writes a register. Wraps naturally at all-ones.
    always_comb begin
        instRet_d = instRet_q;
        if (ValidW) begin
            instRet_d = instRet_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instRet_q <= '0;
        end else begin
            instRet_q <= instRet_d;
        end
    end

    assign InstRet = instRet_q;

endmodule
